// File: rtl/thee_pkg.sv
// Shared types and constants for the testbench reset generator.
// Holds the reset FSM state encoding and the release-count width.
package thee_pkg;

  typedef enum logic [1:0] {
    RS_SYNC,
    RS_HOLD,
    RS_RUN,
    RS_SW
  } rst_state_e;

  localparam int THEE_RST_COUNT_W = 8;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/thee_rst_sync.sv
// Release synchroniser: a chain of flops cleared by rst, shifting in 1s.
// q is the last stage; q_nxt is the value the last stage takes next edge.
module thee_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic q_nxt
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign q     = chain[STAGES-1];
  assign q_nxt = chain[STAGES-2];

endmodule

// File: rtl/thee_rst_gen_module.sv
// Conditioned reset generator: async assert, sync release after a hold,
// timed software resets, release pulse/count and cycles-since-release.
module thee_rst_gen_module
  import thee_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int SW_RST_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sw_rst_req,
  output logic                        rst_out,
  output logic                        rst_out_n,
  output logic                        rst_done,
  output logic [THEE_RST_COUNT_W-1:0] rst_count,
  output logic [CNT_W-1:0]            cycle_cnt
);

  localparam int CMAX = imax(HOLD_CYCLES, SW_RST_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  rst_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sw_q, sw_rise;
  logic sync_q, sync_nxt, sync_go;
  logic out_q, done_q, enter_run;
  logic [THEE_RST_COUNT_W-1:0] count_q;
  logic [CNT_W-1:0] cyc_q;

  thee_rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .q    (sync_q),
    .q_nxt(sync_nxt)
  );

  // Look one stage ahead so the FSM leaves SYNC on the edge the chain fills.
  assign sync_go = sync_nxt | sync_q;
  assign sw_rise = sw_rst_req & ~sw_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RS_SYNC: begin
        if (sync_go) begin
          if (HOLD_CYCLES == 0) begin
            state_d = RS_RUN;
          end else begin
            state_d = RS_HOLD;
            cnt_d   = CW'(HOLD_CYCLES);
          end
        end
      end
      RS_HOLD: begin
        if (cnt_q == CW'(1)) state_d = RS_RUN;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      RS_RUN: begin
        if (sw_rise) begin
          state_d = RS_SW;
          cnt_d   = CW'(SW_RST_CYCLES);
        end
      end
      RS_SW: begin
        if (cnt_q == CW'(1)) state_d = RS_RUN;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RS_SYNC;
    endcase
  end

  assign enter_run = (state_q != RS_RUN) && (state_d == RS_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RS_SYNC;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
      count_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_rst_req;
      out_q   <= (state_d != RS_RUN);
      done_q  <= enter_run;
      if (enter_run && (count_q != '1))
        count_q <= count_q + 1'b1;
      if ((state_q == RS_RUN) && (state_d == RS_RUN))
        cyc_q <= cyc_q + 1'b1;
      else
        cyc_q <= '0;
    end
  end

  assign rst_out   = out_q;
  assign rst_out_n = ~out_q;
  assign rst_done  = done_q;
  assign rst_count = count_q;
  assign cycle_cnt = cyc_q;

endmodule
